mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/dlx_bus_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/bus_decode.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_bus_pkg.sv
// Shared types for the DLX memory bus arbiter:
// FSM states, decode targets, requester ids.
package dlx_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_LED,
        TGT_RAM
    } target_e;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_e;

    localparam logic [31:0] LED_ADDR_DFLT = 32'h0000_0001;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of fetch, data, RAM and LED signals
// between the core side and the arbiter.
interface mem_bus_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    logic        ram_cs;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] led;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  ram_rdata,
        output if_ready, if_rdata,
        output dm_ready, dm_rdata,
        output ram_cs, ram_we, ram_addr, ram_wdata,
        output led, bus_err
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output ram_rdata,
        input  if_ready, if_rdata,
        input  dm_ready, dm_rdata,
        input  ram_cs, ram_we, ram_addr, ram_wdata,
        input  led, bus_err
    );

endinterface

// File: rtl/bus_decode.sv
// Address decode: LED register, null page or RAM.
// LED match takes priority over the null check.
module bus_decode
    import dlx_bus_pkg::*;
#(
    parameter logic [31:0] LED_ADDR = LED_ADDR_DFLT
) (
    input  logic [31:0] addr,
    output target_e     tgt
);

    always_comb begin
        tgt = TGT_RAM;
        if (addr == LED_ADDR) begin
            tgt = TGT_LED;
        end else if (addr == 32'h0) begin
            tgt = TGT_NONE;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one RAM and an LED
// register between the fetch and data ports.
module mem_bus_arbiter
    import dlx_bus_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DFLT
) (
    input logic         clk,
    input logic         rst,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [3:0] LAT = 4'(RAM_LATENCY);

    state_e      state;
    logic [3:0]  cnt;
    port_e       last_gnt;
    port_e       cur_port;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic        if_ready_q;
    logic        dm_ready_q;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic        ram_cs_q;
    logic        ram_we_q;
    logic [31:0] led_q;
    logic        bus_err_q;

    logic        any_req;
    logic        pick_dm;
    port_e       gnt;
    logic [31:0] arb_addr;
    logic        g_we;
    logic [31:0] g_wdata;
    logic [31:0] imm_rdata;
    target_e     tgt;

    // Data wins a tie unless it was the last port served.
    always_comb begin
        any_req  = bus.if_req | bus.dm_req;
        pick_dm  = bus.dm_req &&
                   (!bus.if_req || last_gnt == PORT_IF);
        gnt      = pick_dm ? PORT_DM : PORT_IF;
        arb_addr = pick_dm ? bus.dm_addr : bus.if_addr;
        g_we     = pick_dm & bus.dm_we;
        g_wdata  = pick_dm ? bus.dm_wdata : 32'h0;
        imm_rdata = (tgt == TGT_LED && !g_we) ? led_q : 32'h0;
    end

    bus_decode #(
        .LED_ADDR(LED_ADDR)
    ) u_dec (
        .addr(arb_addr),
        .tgt (tgt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            last_gnt   <= PORT_IF;
            cur_port   <= PORT_IF;
            cur_addr   <= 32'h0;
            cur_wdata  <= 32'h0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            led_q      <= 32'h0;
            bus_err_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            bus_err_q  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        last_gnt  <= gnt;
                        cur_port  <= gnt;
                        cur_addr  <= arb_addr;
                        cur_wdata <= g_wdata;
                        if (tgt == TGT_RAM) begin
                            state    <= ST_RAM_ACC;
                            cnt      <= LAT;
                            ram_cs_q <= 1'b1;
                            ram_we_q <= g_we;
                        end else begin
                            state     <= ST_RESP;
                            bus_err_q <= (tgt == TGT_NONE);
                            if (tgt == TGT_LED && g_we) begin
                                led_q <= g_wdata;
                            end
                            if (pick_dm) begin
                                dm_ready_q <= 1'b1;
                                dm_rdata_q <= imm_rdata;
                            end else begin
                                if_ready_q <= 1'b1;
                                if_rdata_q <= imm_rdata;
                            end
                        end
                    end
                end
                ST_RAM_ACC: begin
                    if (cnt == 4'd1) begin
                        state    <= ST_RESP;
                        cnt      <= 4'd0;
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        if (cur_port == PORT_DM) begin
                            dm_ready_q <= 1'b1;
                            dm_rdata_q <= bus.ram_rdata;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= bus.ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = cur_addr;
    assign bus.ram_wdata = cur_wdata;
    assign bus.led       = led_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter at RAM
// latencies 2 (main), 1 and 15.
module tb_mem_bus_arbiter;

    localparam logic [31:0] LED_A = 32'h0000_0001;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus2 ();
    mem_bus_arbiter_if bus1 ();
    mem_bus_arbiter_if bus15 ();

    mem_bus_arbiter #(
        .RAM_LATENCY(2), .LED_ADDR(LED_A)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    mem_bus_arbiter #(
        .RAM_LATENCY(1), .LED_ADDR(LED_A)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    mem_bus_arbiter #(
        .RAM_LATENCY(15), .LED_ADDR(LED_A)
    ) dut15 (.clk(clk), .rst(rst), .bus(bus15.slave));

    // RAM model: unwritten words read back as a fixed pattern
    logic [31:0] mem [256];
    bit          wvld [256];
    logic [7:0]  ridx;

    assign ridx = bus2.ram_addr[9:2];

    always @(posedge clk) begin
        if (bus2.ram_cs && bus2.ram_we) begin
            mem[ridx]  <= bus2.ram_wdata;
            wvld[ridx] <= 1'b1;
        end
    end

    assign bus2.ram_rdata = !bus2.ram_cs ? 32'h0 :
        (wvld[ridx] ? mem[ridx] : (32'h1000_0000 | {24'h0, ridx}));
    assign bus1.ram_rdata = bus1.ram_cs ?
        (bus1.ram_addr ^ 32'hA5A5_0000) : 32'h0;
    assign bus15.ram_rdata = bus15.ram_cs ?
        (bus15.ram_addr ^ 32'hA5A5_0000) : 32'h0;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        bit          chk;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic drive_idle();
        bus2.if_req = 0; bus2.if_addr = 0;
        bus2.dm_req = 0; bus2.dm_we = 0;
        bus2.dm_addr = 0; bus2.dm_wdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0;
        bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = 0; bus1.dm_wdata = 0;
        bus15.if_req = 0; bus15.if_addr = 0;
        bus15.dm_req = 0; bus15.dm_we = 0;
        bus15.dm_addr = 0; bus15.dm_wdata = 0;
    endtask

    task automatic do_access(
        input string       nm,
        input bit          is_dm,
        input bit          we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] rd_exp,
        input bit          chk_rd,
        input bit          err_exp,
        input int          lat_exp,
        input int          cs_exp,
        output logic [31:0] led_seen
    );
        exp_t e;
        int n, cs;
        bit done, glitch;
        logic [1:0] pexp, pgot;
        logic [31:0] rd;
        e.is_dm = is_dm; e.rdata = rd_exp;
        e.chk = chk_rd; e.err = err_exp;
        sb.push_back(e);
        if (is_dm) begin
            bus2.dm_req = 1; bus2.dm_we = we;
            bus2.dm_addr = addr; bus2.dm_wdata = wdata;
        end else begin
            bus2.if_req = 1; bus2.if_addr = addr;
        end
        n = 0; cs = 0; done = 0; glitch = 0;
        led_seen = '0;
        while (!done && n < 40) begin
            @(posedge clk); #1; n++;
            if (bus2.ram_cs) begin
                cs++;
                if (bus2.ram_we !== we || bus2.ram_addr !== addr)
                    glitch = 1;
            end
            if (bus2.dm_ready || bus2.if_ready) begin
                done = 1;
                led_seen = bus2.led;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s sb_empty: ready with nothing queued", nm);
                end else begin
                    e = sb.pop_front();
                    pexp = e.is_dm ? 2'b10 : 2'b01;
                    pgot = {bus2.dm_ready, bus2.if_ready};
                    if (pgot !== pexp) begin
                        n_fail++;
                        $display("FAIL %s port: got %b want %b", nm, pgot, pexp);
                    end
                    if (e.chk) begin
                        n_chk++;
                        rd = e.is_dm ? bus2.dm_rdata : bus2.if_rdata;
                        if (rd !== e.rdata) begin
                            n_fail++;
                            $display("FAIL %s rdata: got %h want %h", nm, rd, e.rdata);
                        end
                    end
                    n_chk++;
                    if (bus2.bus_err !== e.err) begin
                        n_fail++;
                        $display("FAIL %s bus_err: got %b want %b", nm, bus2.bus_err, e.err);
                    end
                end
            end else if (bus2.if_rdata !== 0 || bus2.dm_rdata !== 0 ||
                         bus2.bus_err !== 0) begin
                glitch = 1;
            end
        end
        bus2.dm_req = 0; bus2.if_req = 0; bus2.dm_we = 0;
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: no ready after %0d cycles", nm, n);
        end
        n_chk++;
        if (n !== lat_exp) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, n, lat_exp);
        end
        n_chk++;
        if (cs !== cs_exp) begin
            n_fail++;
            $display("FAIL %s ram_cs_cycles: got %0d want %0d", nm, cs, cs_exp);
        end
        n_chk++;
        if (glitch !== 1'b0) begin
            n_fail++;
            $display("FAIL %s bus_glitch: got 1 want 0", nm);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({bus2.if_ready, bus2.dm_ready, bus2.ram_cs,
             bus2.ram_we, bus2.bus_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                {bus2.if_ready, bus2.dm_ready, bus2.ram_cs,
                 bus2.ram_we, bus2.bus_err});
        end
        n_chk++;
        if (bus2.led !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_led: got %h want 0", bus2.led);
        end
        n_chk++;
        if ((bus2.if_rdata | bus2.dm_rdata | bus2.ram_addr) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                bus2.if_rdata | bus2.dm_rdata | bus2.ram_addr);
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        exp_t e;
        int n, got, first_n;
        logic [1:0] pexp, pgot;
        logic [31:0] rd;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            e.is_dm = (i % 2 == 0);
            e.rdata = e.is_dm ? 32'h1000_0080 : 32'h1000_00C0;
            e.chk = 1; e.err = 0;
            sb.push_back(e);
        end
        bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 32'h200;
        bus2.if_req = 1; bus2.if_addr = 32'h300;
        n = 0; got = 0; first_n = 0;
        while (got < 4 && n < 80) begin
            @(posedge clk); #1; n++;
            if (bus2.dm_ready || bus2.if_ready) begin
                if (got == 0) first_n = n;
                got++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL arb_sb_empty: extra ready");
                end else begin
                    e = sb.pop_front();
                    pexp = e.is_dm ? 2'b10 : 2'b01;
                    pgot = {bus2.dm_ready, bus2.if_ready};
                    if (pgot !== pexp) begin
                        n_fail++;
                        $display("FAIL arb_order[%0d]: got %b want %b", got, pgot, pexp);
                    end
                    n_chk++;
                    rd = e.is_dm ? bus2.dm_rdata : bus2.if_rdata;
                    if (rd !== e.rdata) begin
                        n_fail++;
                        $display("FAIL arb_rdata[%0d]: got %h want %h", got, rd, e.rdata);
                    end
                end
            end
        end
        bus2.dm_req = 0; bus2.if_req = 0;
        n_chk++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL arb_count: got %0d want 4", got);
            sb.delete();
        end
        n_chk++;
        if (first_n !== 3) begin
            n_fail++;
            $display("FAIL arb_first_latency: got %0d want 3", first_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ram();
        logic [31:0] l;
        do_access("ram_wr", 1, 1, 32'h100, 32'hDEAD_BEEF,
                  32'h0, 0, 0, 3, 2, l);
        do_access("ram_rd", 1, 0, 32'h100, 32'h0,
                  32'hDEAD_BEEF, 1, 0, 3, 2, l);
        do_access("fetch_rd", 0, 0, 32'h304, 32'h0,
                  32'h1000_00C1, 1, 0, 3, 2, l);
    endtask

    task automatic test_led();
        logic [31:0] l;
        do_access("led_wr", 1, 1, LED_A, 32'h0000_00A5,
                  32'h0, 0, 0, 1, 0, l);
        n_chk++;
        if (l !== 32'hA5) begin
            n_fail++;
            $display("FAIL led_at_ready: got %h want a5", l);
        end
        do_access("led_rd", 0, 0, LED_A, 32'h0,
                  32'hA5, 1, 0, 1, 0, l);
    endtask

    task automatic test_bus_err();
        logic [31:0] l;
        do_access("null_if_rd", 0, 0, 32'h0, 32'h0,
                  32'h0, 1, 1, 1, 0, l);
        n_chk++;
        if (l !== 32'hA5) begin
            n_fail++;
            $display("FAIL null_rd_led: got %h want a5", l);
        end
        do_access("null_dm_wr", 1, 1, 32'h0, 32'h1234_5678,
                  32'h0, 1, 1, 1, 0, l);
        n_chk++;
        if (bus2.led !== 32'hA5) begin
            n_fail++;
            $display("FAIL null_wr_led: got %h want a5", bus2.led);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] l;
        bit seen;
        bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 32'h200;
        @(posedge clk); #1;
        n_chk++;
        if (bus2.ram_cs !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_cs_start: got %b want 1", bus2.ram_cs);
        end
        rst = 1;
        bus2.dm_req = 0;
        @(posedge clk); #1;
        n_chk++;
        if ({bus2.ram_cs, bus2.dm_ready, bus2.if_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b want 000",
                {bus2.ram_cs, bus2.dm_ready, bus2.if_ready});
        end
        n_chk++;
        if (bus2.led !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_led: got %h want 0", bus2.led);
        end
        rst = 0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus2.dm_ready || bus2.if_ready || bus2.ram_cs) seen = 1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_ready: got activity want none");
        end
        do_access("abort_idle_led", 1, 0, LED_A, 32'h0,
                  32'h0, 1, 0, 1, 0, l);
    endtask

    task automatic test_latency();
        int n, l1, l15;
        logic [31:0] d1, d15;
        bus1.dm_req = 1; bus1.dm_addr = 32'h40;
        bus15.dm_req = 1; bus15.dm_addr = 32'h40;
        n = 0; l1 = 0; l15 = 0; d1 = 0; d15 = 0;
        while ((l1 == 0 || l15 == 0) && n < 40) begin
            @(posedge clk); #1; n++;
            if (bus1.dm_ready) begin
                l1 = n; d1 = bus1.dm_rdata; bus1.dm_req = 0;
            end
            if (bus15.dm_ready) begin
                l15 = n; d15 = bus15.dm_rdata; bus15.dm_req = 0;
            end
        end
        bus1.dm_req = 0; bus15.dm_req = 0;
        n_chk++;
        if (l1 !== 2) begin
            n_fail++;
            $display("FAIL lat1: got %0d want 2", l1);
        end
        n_chk++;
        if (l15 !== 16) begin
            n_fail++;
            $display("FAIL lat15: got %0d want 16", l15);
        end
        n_chk++;
        if (d1 !== 32'hA5A5_0040) begin
            n_fail++;
            $display("FAIL lat1_rdata: got %h want a5a50040", d1);
        end
        n_chk++;
        if (d15 !== 32'hA5A5_0040) begin
            n_fail++;
            $display("FAIL lat15_rdata: got %h want a5a50040", d15);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_ram();
        test_led();
        test_bus_err();
        test_reset_abort();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
